// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single register-file write port among three write-back
//   requesters (ALU, LOAD, MUL) using a round-robin pointer. The accepted
//   write is registered onto wr_en/a3/wd for one cycle, together with the
//   index of the winning requester and a one-hot busy scoreboard.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous, active-low reset
//   req_valid  in   [2:0]      bit0 = ALU, bit1 = LOAD, bit2 = MUL
//   req_addr   in   [3*AW-1:0] requester i at [i*AW +: AW]
//   req_data   in   [3*DW-1:0] requester i at [i*DW +: DW]
//   req_ready  out  [2:0]      one-hot or zero accept, combinational
//   wr_en      out             register-file write enable (registered)
//   a3         out  [AW-1:0]   register-file write address (registered)
//   wd         out  [DW-1:0]   register-file write data (registered)
//   grant_id   out  [1:0]      requester owning the output stage, 3 = none
//   busy       out  [31:0]     bit r set while a write to r is in the output stage
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req_valid,
  input  logic [3*AW-1:0]   req_addr,
  input  logic [3*DW-1:0]   req_data,
  output logic [2:0]        req_ready,
  output logic              wr_en,
  output logic [AW-1:0]     a3,
  output logic [DW-1:0]     wd,
  output logic [1:0]        grant_id,
  output logic [31:0]       busy
);

  localparam logic [1:0] NO_GRANT = 2'd3;

  // Round-robin pointer: only 0..2 are ever loaded.
  logic [1:0]    rr_ptr_q, rr_ptr_d;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic [31:0]   busy_q, busy_d;

  // Arbitration result for the current cycle.
  logic          gnt_valid;
  logic [1:0]    gnt_idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // -------------------------------------------------------------------------
  // Round-robin pick: first valid requester at or after rr_ptr, modulo 3.
  // -------------------------------------------------------------------------
  always_comb begin
    int unsigned j;
    // NOTE: every variable driven here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    gnt_valid = 1'b0;
    gnt_idx   = NO_GRANT;
    j         = 0;
    for (int k = 0; k < 3; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= 3) j = j - 3;
      if (!gnt_valid && req_valid[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'(j);
      end
    end
    // Nothing may be accepted while reset is asserted.
    if (!rst_n) begin
      gnt_valid = 1'b0;
      gnt_idx   = NO_GRANT;
    end
  end

  always_comb begin
    req_ready = 3'b000;
    if (gnt_valid) req_ready[gnt_idx] = 1'b1;
  end

  // Mux the winner's address and data; gnt_idx = 3 never reaches the
  // default arm with gnt_valid set, so its value there is irrelevant.
  always_comb begin
    sel_addr = req_addr[2*AW +: AW];
    sel_data = req_data[2*DW +: DW];
    case (gnt_idx)
      2'd0: begin
        sel_addr = req_addr[0 +: AW];
        sel_data = req_data[0 +: DW];
      end
      2'd1: begin
        sel_addr = req_addr[AW +: AW];
        sel_data = req_data[DW +: DW];
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state for the output stage and the pointer.
  // -------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_en_d    = 1'b0;
    a3_d       = a3_q;
    wd_d       = wd_q;
    grant_id_d = NO_GRANT;
    if (gnt_valid) begin
      // Register 0 is hard-wired: accept the write, but never enable it.
      wr_en_d    = (sel_addr != '0);
      a3_d       = sel_addr;
      wd_d       = sel_data;
      grant_id_d = gnt_idx;
      rr_ptr_d   = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
    // Scoreboard tracks exactly the register being written this cycle.
    busy_d = wr_en_d ? (32'd1 << a3_d) : 32'd0;
  end

  // -------------------------------------------------------------------------
  // State registers.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= 2'd0;
      wr_en_q    <= 1'b0;
      a3_q       <= '0;
      wd_q       <= '0;
      grant_id_q <= NO_GRANT;
      busy_q     <= 32'd0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      a3_q       <= a3_d;
      wd_q       <= wd_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign a3       = a3_q;
  assign wd       = wd_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Self-checking bench for rf_wb_arbiter. A behavioural model (plain
//   integer round-robin search plus the last accepted write) predicts
//   req_ready before each edge and the registered outputs after it.
//   Directed scenarios pin the model with literal expectations, then a
//   randomized phase drives requesters that hold their request until
//   accepted (with occasional abandonment).
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk;
  logic              rst_n;
  logic [2:0]        req_valid;
  logic [3*AW-1:0]   req_addr;
  logic [3*DW-1:0]   req_data;
  logic [2:0]        req_ready;
  logic              wr_en;
  logic [AW-1:0]     a3;
  logic [DW-1:0]     wd;
  logic [1:0]        grant_id;
  logic [31:0]       busy;

  // Per-requester stimulus.
  logic          v [3];
  logic [AW-1:0] a [3];
  logic [DW-1:0] d [3];

  assign req_valid = {v[2], v[1], v[0]};
  assign req_addr  = {a[2], a[1], a[0]};
  assign req_data  = {d[2], d[1], d[0]};

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .a3        (a3),
    .wd        (wd),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  int            m_rr;
  logic          m_wr;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;
  int            m_gid;
  int            m_last_g;
  logic [2:0]    last_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr     = 0;
    m_wr     = 1'b0;
    m_a3     = '0;
    m_wd     = '0;
    m_gid    = 3;
    m_last_g = -1;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (m_rr + k) % 3;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    for (int r = 0; r < 32; r++) b[r] = m_wr && (int'(m_a3) == r);
    return b;
  endfunction

  task automatic compare_outputs();
    check("wr_en",    64'(wr_en),    64'(m_wr));
    check("a3",       64'(a3),       64'(m_a3));
    check("wd",       64'(wd),       64'(m_wd));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    check("busy",     64'(busy),     64'(model_busy()));
  endtask

  // One clock cycle: predict/check ready, advance model, check outputs.
  task automatic tick();
    int g;
    logic [2:0] er;
    #1;
    g  = model_pick();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    check("req_ready", 64'(req_ready), 64'(er));
    last_ready = req_ready;
    if (g >= 0) begin
      m_a3  = a[g];
      m_wd  = d[g];
      m_gid = g;
      m_wr  = (a[g] != '0);
      m_rr  = (g + 1) % 3;
    end else begin
      m_wr  = 1'b0;
      m_gid = 3;
    end
    m_last_g = g;
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic drive(input logic [2:0] vv,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    v[0] = vv[0]; v[1] = vv[1]; v[2] = vv[2];
    a[0] = a0; a[1] = a1; a[2] = a2;
    d[0] = d0; d[1] = d1; d[2] = d2;
  endtask

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gid_seq [6];
    int a3_seq  [6];
    int mul_hits;
    gid_seq = '{0, 1, 2, 0, 1, 2};
    a3_seq  = '{1, 2, 3, 1, 2, 3};

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    model_reset();
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    #12;
    check("rst_ready",    64'(req_ready), 64'd0);
    check("rst_wr_en",    64'(wr_en),     64'd0);
    check("rst_a3",       64'(a3),        64'd0);
    check("rst_wd",       64'(wd),        64'd0);
    check("rst_grant_id", 64'(grant_id),  64'd3);
    check("rst_busy",     64'(busy),      64'd0);
    #4;
    rst_n = 1'b1;

    // ---------------- 3-way round robin, 6 cycles ----------------
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_gid_lit", 64'(grant_id), 64'(gid_seq[i]));
      check("rr_a3_lit",  64'(a3),       64'(a3_seq[i]));
      check("rr_wen_lit", 64'(wr_en),    64'd1);
    end

    // ---------------- single LOAD write ----------------
    drive(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0);
    tick();
    check("load_wen_lit",  64'(wr_en),    64'd1);
    check("load_a3_lit",   64'(a3),       64'd5);
    check("load_wd_lit",   64'(wd),       64'hDEADBEEF);
    check("load_busy_lit", 64'(busy),     64'h20);
    check("load_gid_lit",  64'(grant_id), 64'd1);

    // ---------------- rr_ptr=2: MUL before ALU ----------------
    drive(3'b101, 5'd9, 5'd0, 5'd10, 32'hA1, 32'h0, 32'hC3);
    check("idle_wen_lit", 64'(wr_en), 64'd1);
    tick();
    check("rr2_first_lit", 64'(grant_id), 64'd2);
    check("rr2_a3_lit",    64'(a3),       64'd10);
    v[2] = 1'b0;
    tick();
    check("rr2_second_lit", 64'(grant_id), 64'd0);
    check("rr2_wd_lit",     64'(wd),       64'hA1);

    // ---------------- idle cycle ----------------
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check("idle_gid_lit",  64'(grant_id), 64'd3);
    check("idle_busy_lit", 64'(busy),     64'd0);
    check("idle_a3_hold",  64'(a3),       64'd9);

    // ---------------- write to register 0 ----------------
    drive(3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0);
    tick();
    check("r0_ready_lit", 64'(last_ready), 64'b001);
    check("r0_wen_lit",   64'(wr_en),      64'd0);
    check("r0_gid_lit",   64'(grant_id),   64'd0);
    check("r0_busy_lit",  64'(busy),       64'd0);
    check("r0_wd_lit",    64'(wd),         64'h1234);

    // ---------------- async reset while wr_en=1 ----------------
    drive(3'b001, 5'd7, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0);
    tick();
    check("pre_rst_wen_lit", 64'(wr_en), 64'd1);
    v[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wen",   64'(wr_en),     64'd0);
    check("arst_busy",  64'(busy),      64'd0);
    check("arst_gid",   64'(grant_id),  64'd3);
    check("arst_ready", 64'(req_ready), 64'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
    drive(3'b111, 5'd4, 5'd6, 5'd8, 32'h44, 32'h66, 32'h88);
    tick();
    check("post_rst_alu_lit", 64'(grant_id), 64'd0);

    // ---------------- MUL waits behind LOAD, appears once ----------------
    // rr_ptr is 1 here, so LOAD beats MUL on the first cycle.
    drive(3'b110, 5'd0, 5'd12, 5'd13, 32'h0, 32'hB0B0, 32'hFACE);
    mul_hits = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) check("mul_wait_ready_lit", 64'(last_ready), 64'b010);
      check("mul_data_stable", 64'(d[2]), 64'hFACE);
      if (grant_id == 2'd2) begin
        mul_hits++;
        check("mul_wd_lit", 64'(wd), 64'hFACE);
      end
      if (m_last_g >= 0) v[m_last_g] = 1'b0;
    end
    check("mul_once_lit", 64'(mul_hits), 64'd1);

    // ---------------- randomized phase ----------------
    m_last_g = -1;
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (v[i] && i != m_last_g) begin
          if ($urandom_range(19) == 0) v[i] = 1'b0;
        end else begin
          v[i] = 1'($urandom_range(1));
          a[i] = ($urandom_range(3) == 0) ? '0 : AW'($urandom);
          d[i] = $urandom;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: DW, 32, write-data width.
REQ-002 Parameter: AW, 5, register-address width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  3  per-requester write request; bit0 = ALU, bit1 = LOAD, bit2 = MUL.
REQ-006 req_addr  in  3*AW  per-requester destination register; requester i occupies bits [i*AW +: AW].
REQ-007 req_data  in  3*DW  per-requester write data; requester i occupies bits [i*DW +: DW].
REQ-008 req_ready  out  3  per-requester accept; a transfer occurs when valid and ready are both 1 on a rising edge.
REQ-009 wr_en  out  1  register-file write enable, registered.
REQ-010 a3  out  AW  register-file write address, registered.
REQ-011 wd  out  DW  register-file write data, registered.
REQ-012 grant_id  out  2  index of the requester whose write is on wr_en/a3/wd; 3 = none.
REQ-013 busy  out  32  scoreboard; bit r = 1 while a write to register r is in the output stage.

Function
REQ-014 The block SHALL share the single register-file write port among the three requesters.
REQ-015 At most one req_ready bit SHALL be 1 in any cycle.
REQ-016 req_ready SHALL be combinational from req_valid and the round-robin pointer.
REQ-017 req_ready[i] SHALL be 1 only if req_valid[i] is 1 and i is the first valid requester at or after rr_ptr, searching upward modulo 3.
REQ-018 rr_ptr SHALL be a 2-bit register holding 0..2; value 3 SHALL never occur.
REQ-019 After a grant to requester i, rr_ptr SHALL become (i+1) mod 3; 2 wraps to 0.
REQ-020 rr_ptr SHALL hold its value in cycles with no grant.
REQ-021 A requester SHALL keep valid, addr and data stable until accepted; the block does not check this.
REQ-022 Latency: a transfer accepted on edge N SHALL drive wr_en/a3/wd/grant_id from edge N until edge N+1.
REQ-023 Throughput: one write per cycle; continuous requests SHALL be accepted back-to-back with no bubble.
REQ-024 Writes to address 0 SHALL be accepted (ready=1); a3, wd and grant_id update as for any write, but wr_en SHALL stay 0 and busy[0] SHALL stay 0.
REQ-025 With no transfer on an edge: wr_en SHALL become 0, grant_id SHALL become 3, and a3/wd SHALL hold.
REQ-026 busy SHALL be one-hot or zero: bit a3 is set exactly when wr_en is 1.
REQ-027 With all three valid, grant order from rr_ptr=0 SHALL be 0,1,2,0,...
REQ-028 With one persistent requester, it SHALL be granted every cycle regardless of rr_ptr.
REQ-029 A requester dropping valid without being accepted SHALL not affect rr_ptr.
REQ-030 Two requesters targeting the same register SHALL be serialised in grant order; the later grant overwrites.

Reset
REQ-031 rst_n low SHALL immediately (asynchronously) force: wr_en=0, a3=0, wd=0, grant_id=3, busy=0, rr_ptr=0.
REQ-032 While rst_n is low, req_ready SHALL be 0.
REQ-033 On deassertion, the first grant SHALL follow rr_ptr=0 priority.
REQ-034 Reset asserted while wr_en=1 SHALL drop wr_en at once; no write is issued for that transfer.

Verification
REQ-035 Reset release, req_valid=3'b111 held for 6 cycles, addrs 1/2/3 -> grant_id sequence 0,1,2,0,1,2; a3 = 1,2,3,1,2,3; wr_en=1 every cycle.
REQ-036 Only LOAD valid, addr=5, data=32'hDEADBEEF, one cycle -> next cycle wr_en=1, a3=5, wd=32'hDEADBEEF, busy=32'h20, grant_id=1; following cycle wr_en=0, grant_id=3, busy=0.
REQ-037 ALU writes addr 0, data 32'h1234 -> req_ready[0]=1; next cycle wr_en=0, grant_id=0, busy=0.
REQ-038 rr_ptr=2 (after grant to LOAD), ALU and MUL valid -> MUL granted first, then ALU.
REQ-039 rst_n pulsed low mid-cycle while wr_en=1 -> wr_en, busy and grant_id clear without waiting for clk; after release, ALU wins a 3-way contention.
REQ-040 MUL held valid 4 cycles, not ready on the first because LOAD won -> MUL data unchanged on each cycle until ready, then appears exactly once on wd.
